seg7_scan_counter: RTL and testbench
====================================

// Module: seg7_scan_counter
// PURPOSE
//  Parametrised multi-digit 7-segment counter/driver; successor to the single-digit hex display.
//  - Prescaled up/down counter, hex or BCD per digit, with synchronous load and clear.
//  - Time-multiplexes digits onto one shared segment bus with a one-hot digit select.
//  - Sits between the top-level pin wrapper (uo_out/uio_out) and the user controls on ui_in.
// PARAMETERS
//  NUM_DIGITS  4           digits driven, 1..8
//  TICK_DIV    25_000_000  clk cycles per count step, >=2
//  SCAN_DIV    12_500      clk cycles each digit is shown, >=1
//  DECIMAL     0           0: digit modulus 16 (hex); 1: modulus 10 (BCD)
//  BLANK_LZ    0           1: blank leading zero digits; digit 0 is never blanked
// PORTS
//  clk       in   1             system clock
//  rst_n     in   1             asynchronous reset, active low
//  en        in   1             1: prescaler runs; 0: prescaler and count hold
//  up_dn     in   1             1: count up; 0: count down
//  clear     in   1             synchronous clear of count and prescaler
//  load      in   1             synchronous load of load_val
//  load_val  in   4*NUM_DIGITS  packed digits, digit 0 in [3:0]
//  value     out  4*NUM_DIGITS  current count, packed like load_val
//  wrap      out  1             one-cycle pulse on full-range wrap
//  seg       out  7             segments {g,f,e,d,c,b,a}, active high
//  dig_sel   out  NUM_DIGITS    one-hot digit enable, active high
// BEHAVIOUR
//  - Reset: value=0, prescaler=0, scan index=0, wrap=0, seg=7'h00, dig_sel=0.
//  - Prescaler counts 0..TICK_DIV-1 while en=1. The internal tick fires in the cycle it equals
//    TICK_DIV-1, and it returns to 0 on that cycle.
//  - Priority per cycle: clear > load > tick.
//    clear: value=0, prescaler=0.  load: value=load_val, prescaler=0.
//  - Loaded digits >9 in DECIMAL=1: stored as given. The next up-step of that digit gives 0 with carry.
//    The next down-step decrements normally.
//  - Tick, up: digit 0 increments. A digit at modulus-1 goes to 0 and carries into the next digit.
//  - Tick, down: a digit at 0 goes to modulus-1 and borrows from the next digit.
//  - Carry/borrow resolve within the same cycle across all digits; value updates 1 cycle after the tick.
//  - wrap=1 for exactly the cycle value changes from all-max to 0 (up) or from 0 to all-max (down).
//    It never asserts on clear or load.
//  - Scan: a divider counts 0..SCAN_DIV-1 and, on terminal count, advances the scan index
//    0..NUM_DIGITS-1, wrapping to 0. It runs regardless of en, clear and load.
//  - seg and dig_sel are registered together from (scan index, value); latency 1 cycle. They never
//    show a mixed digit/segment pair.
//  - dig_sel=1<<scan index. seg is the digit glyph; a blanked digit gives seg=7'h00 with dig_sel still asserted.
//  - Glyphs 0-F:
//    3F 06 5B 4F 66 6D 7D 07 7F 6F 77 7C 39 5E 79 71
//  - Blanking: digit i (i>0) is blanked iff it and all higher digits are 0.
//  - rst_n asserted mid-count: all state clears immediately (async). Release is synchronous to clk
//    at the board level.
// STRUCTURE
//  - Package seg7_pkg holds:
//    SEG_GLYPH[16] table; seg7_t (logic [6:0]); function digit_max(DECIMAL).
//  - Sub-module seg7_digit_cell (one per digit, generate loop):
//    4-bit register; inputs inc/dec/carry_in/load/clear; outputs carry_out and is_zero/is_max.
//  - Top holds the prescaler, the scan divider, the output register and the glyph lookup.
// TESTING (bench: NUM_DIGITS=2, TICK_DIV=4, SCAN_DIV=2, DECIMAL=1 unless stated)
//  - Reset, then en=1 up for 40 cycles:
//    value steps 00,01,.. every 4 clk; first step 4 clk after release; value=10 after 40 clk.
//  - load_val=8'h99, load, up, one tick -> value=00; wrap high exactly 1 cycle.
//    Then down one tick -> value=99 with wrap pulse.
//  - clear and load in the same cycle with en=1 at tick -> value=00; prescaler restarts; no wrap.
//  - en=0 for 20 cycles mid-count -> value and prescaler frozen.
//    Scan continues: dig_sel alternates 01,10 every 2 clk.
//  - value=07, BLANK_LZ=1 -> digit1 slot gives seg=00 with dig_sel=10; digit0 slot gives seg=07.
//    With BLANK_LZ=0, digit1 slot gives seg=3F.
//  - DECIMAL=0, NUM_DIGITS=1 -> 0..F glyph sequence matches the table, then wraps to 0 with wrap pulse.
//    Assert rst_n mid-tick -> outputs reach reset values with no clk edge.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared types, glyph table and digit-range helper for the 7-segment scan counter.
package seg7_pkg;

  typedef logic [6:0] seg7_t;

  // Segment order {g,f,e,d,c,b,a}, active high.
  localparam seg7_t SEG_GLYPH [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  function automatic logic [3:0] digit_max(input bit decimal);
    return decimal ? 4'd9 : 4'd15;
  endfunction

endpackage

// File: rtl/seg7_digit_cell.sv
// One counter digit: 4-bit register stepping on carry_in, rolling over into carry_out.
module seg7_digit_cell
  import seg7_pkg::*;
#(
  parameter bit DECIMAL = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       inc,
  input  logic       dec,
  input  logic       carry_in,
  input  logic       load,
  input  logic       clear,
  input  logic [3:0] load_d,
  output logic [3:0] q,
  output logic       carry_out,
  output logic       is_zero,
  output logic       is_max
);

  localparam logic [3:0] MAX = digit_max(DECIMAL);

  logic roll_up;

  // Loaded out-of-range BCD digits roll to 0 on the next up-step.
  assign roll_up   = (q >= MAX);
  assign is_zero   = (q == 4'd0);
  assign is_max    = (q == MAX);
  assign carry_out = carry_in && ((inc && roll_up) || (dec && is_zero));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= 4'd0;
    end else if (clear) begin
      q <= 4'd0;
    end else if (load) begin
      q <= load_d;
    end else if (carry_in && inc) begin
      q <= roll_up ? 4'd0 : q + 4'd1;
    end else if (carry_in && dec) begin
      q <= is_zero ? MAX : q - 4'd1;
    end
  end

endmodule

// File: rtl/seg7_scan_counter.sv
// Prescaled multi-digit up/down counter with time-multiplexed 7-segment output.
module seg7_scan_counter
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int TICK_DIV   = 25_000_000,
  parameter int SCAN_DIV   = 12_500,
  parameter bit DECIMAL    = 1'b0,
  parameter bit BLANK_LZ   = 1'b0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic                    up_dn,
  input  logic                    clear,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] load_val,
  output logic [4*NUM_DIGITS-1:0] value,
  output logic                    wrap,
  output seg7_t                   seg,
  output logic [NUM_DIGITS-1:0]   dig_sel
);

  localparam int PW = $clog2(TICK_DIV);
  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  logic [PW-1:0]         tick_rem;
  logic [SW-1:0]         scan_rem;
  logic [IW-1:0]         scan_idx;
  logic                  tick;
  logic                  step;
  logic [NUM_DIGITS:0]   carry;
  logic [NUM_DIGITS-1:0] is_zero;
  logic [NUM_DIGITS-1:0] is_max;
  logic [3:0]            digit [NUM_DIGITS];
  logic [3:0]            cur_digit;
  logic                  blank;
  logic                  all_zero;

  // Prescaler is a down-counter; remaining==0 is the same cycle an up-count would hit TICK_DIV-1.
  assign tick     = en && (tick_rem == '0);
  assign step     = tick && !clear && !load;
  assign carry[0] = step;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_rem <= PW'(TICK_DIV - 1);
    end else if (clear || load) begin
      tick_rem <= PW'(TICK_DIV - 1);
    end else if (en) begin
      tick_rem <= (tick_rem == '0) ? PW'(TICK_DIV - 1) : tick_rem - PW'(1);
    end
  end

  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
    seg7_digit_cell #(.DECIMAL(DECIMAL)) u_cell (
      .clk       (clk),
      .rst_n     (rst_n),
      .inc       (up_dn),
      .dec       (!up_dn),
      .carry_in  (carry[i]),
      .load      (load),
      .clear     (clear),
      .load_d    (load_val[4*i +: 4]),
      .q         (digit[i]),
      .carry_out (carry[i+1]),
      .is_zero   (is_zero[i]),
      .is_max    (is_max[i])
    );
    assign value[4*i +: 4] = digit[i];
  end

  // Carry out of the top digit alone is not enough: a loaded out-of-range digit can also roll.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrap <= 1'b0;
    end else begin
      wrap <= carry[NUM_DIGITS] && (up_dn ? (&is_max) : (&is_zero));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_rem <= SW'(SCAN_DIV - 1);
      scan_idx <= '0;
    end else if (scan_rem == '0) begin
      scan_rem <= SW'(SCAN_DIV - 1);
      scan_idx <= (scan_idx == IW'(NUM_DIGITS - 1)) ? '0 : scan_idx + IW'(1);
    end else begin
      scan_rem <= scan_rem - SW'(1);
    end
  end

  // Walk from the top digit down so all_zero covers the selected digit and everything above it.
  always_comb begin
    cur_digit = 4'd0;
    blank     = 1'b0;
    all_zero  = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      all_zero = all_zero && is_zero[i];
      if (scan_idx == IW'(i)) begin
        cur_digit = digit[i];
        blank     = BLANK_LZ && (i > 0) && all_zero;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg     <= '0;
      dig_sel <= '0;
    end else begin
      seg     <= blank ? seg7_t'(0) : SEG_GLYPH[cur_digit];
      dig_sel <= NUM_DIGITS'(1) << scan_idx;
    end
  end

endmodule

// File: tb/tb_seg7_scan_counter.sv
// Scoreboard bench: three counter configurations share one stimulus stream.
module tb_seg7_scan_counter;

  localparam int TD = 4;
  localparam int SD = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic       up_dn = 1'b1;
  logic       clear = 1'b0;
  logic       load = 1'b0;
  logic [7:0] load_val = 8'h00;

  logic [7:0] value_a, value_b;
  logic       wrap_a, wrap_b, wrap_c;
  logic [6:0] seg_a, seg_b, seg_c;
  logic [1:0] dig_a, dig_b;
  logic [3:0] value_c;
  logic [0:0] dig_c;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  seg7_scan_counter #(.NUM_DIGITS(2), .TICK_DIV(TD), .SCAN_DIV(SD), .DECIMAL(1), .BLANK_LZ(0)) dut_a (
    .clk(clk), .rst_n(rst_n), .en(en), .up_dn(up_dn), .clear(clear), .load(load),
    .load_val(load_val), .value(value_a), .wrap(wrap_a), .seg(seg_a), .dig_sel(dig_a));

  seg7_scan_counter #(.NUM_DIGITS(2), .TICK_DIV(TD), .SCAN_DIV(SD), .DECIMAL(1), .BLANK_LZ(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .en(en), .up_dn(up_dn), .clear(clear), .load(load),
    .load_val(load_val), .value(value_b), .wrap(wrap_b), .seg(seg_b), .dig_sel(dig_b));

  seg7_scan_counter #(.NUM_DIGITS(1), .TICK_DIV(TD), .SCAN_DIV(SD), .DECIMAL(0), .BLANK_LZ(0)) dut_c (
    .clk(clk), .rst_n(rst_n), .en(en), .up_dn(up_dn), .clear(clear), .load(load),
    .load_val(load_val[3:0]), .value(value_c), .wrap(wrap_c), .seg(seg_c), .dig_sel(dig_c));

  logic [6:0] glyph [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                             7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: the count is a plain integer, digits are derived by division.
  typedef struct {
    int         k;
    logic [7:0] value;
    logic       wrap;
    logic [6:0] seg;
    logic [1:0] dig;
  } exp_t;

  exp_t sbq[$];
  int   m_cnt [3];
  int   m_ps  [3];
  int   m_sd  [3];
  int   m_idx [3];
  int   nd [3] = '{2, 2, 1};
  int   md [3] = '{10, 10, 16};
  bit   bl [3] = '{1'b0, 1'b1, 1'b0};

  function automatic int pw(input int b, input int e);
    int r = 1;
    for (int i = 0; i < e; i++) r = r * b;
    return r;
  endfunction

  function automatic logic [7:0] pack(input int k, input int c);
    logic [7:0] r = 8'h00;
    for (int i = 0; i < nd[k]; i++) r[4*i +: 4] = 4'((c / pw(md[k], i)) % md[k]);
    return r;
  endfunction

  function automatic int unpack(input int k, input logic [7:0] lv);
    int r = 0;
    for (int i = 0; i < nd[k]; i++) r = r + int'(lv[4*i +: 4]) * pw(md[k], i);
    return r;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 3; k++) begin
        m_cnt[k] = 0; m_ps[k] = 0; m_sd[k] = 0; m_idx[k] = 0;
      end
      sbq.delete();
    end else begin
      for (int k = 0; k < 3; k++) begin
        exp_t e;
        int   top;
        int   hi;
        top   = pw(md[k], nd[k]);
        hi    = m_cnt[k] / pw(md[k], m_idx[k]);
        e.k   = k;
        e.seg = (bl[k] && m_idx[k] > 0 && hi == 0) ? 7'h00 : glyph[hi % md[k]];
        e.dig = 2'(1 << m_idx[k]);
        e.wrap = 1'b0;
        if (clear) begin
          m_cnt[k] = 0; m_ps[k] = 0;
        end else if (load) begin
          m_cnt[k] = unpack(k, load_val); m_ps[k] = 0;
        end else if (en) begin
          if (m_ps[k] == TD - 1) begin
            m_ps[k] = 0;
            if (up_dn) begin
              if (m_cnt[k] == top - 1) begin m_cnt[k] = 0; e.wrap = 1'b1; end
              else m_cnt[k]++;
            end else begin
              if (m_cnt[k] == 0) begin m_cnt[k] = top - 1; e.wrap = 1'b1; end
              else m_cnt[k]--;
            end
          end else begin
            m_ps[k]++;
          end
        end
        if (m_sd[k] == SD - 1) begin
          m_sd[k]  = 0;
          m_idx[k] = (m_idx[k] + 1) % nd[k];
        end else begin
          m_sd[k]++;
        end
        e.value = pack(k, m_cnt[k]);
        sbq.push_back(e);
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      while (sbq.size() > 0) begin
        e = sbq.pop_front();
        case (e.k)
          0: begin
            check("a_value", 32'(value_a), 32'(e.value));
            check("a_wrap", 32'(wrap_a), 32'(e.wrap));
            check("a_seg", 32'(seg_a), 32'(e.seg));
            check("a_dig", 32'(dig_a), 32'(e.dig));
          end
          1: begin
            check("b_value", 32'(value_b), 32'(e.value));
            check("b_wrap", 32'(wrap_b), 32'(e.wrap));
            check("b_seg", 32'(seg_b), 32'(e.seg));
            check("b_dig", 32'(dig_b), 32'(e.dig));
          end
          default: begin
            check("c_value", 32'(value_c), 32'(e.value));
            check("c_wrap", 32'(wrap_c), 32'(e.wrap));
            check("c_seg", 32'(seg_c), 32'(e.seg));
            check("c_dig", 32'(dig_c), 32'(e.dig));
          end
        endcase
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    repeat (3) @(negedge clk);
    check("rst_value", 32'(value_a), 32'h0);
    check("rst_wrap", 32'(wrap_a), 32'h0);
    check("rst_seg", 32'(seg_a), 32'h0);
    check("rst_dig", 32'(dig_a), 32'h0);

    rst_n = 1'b1; en = 1'b1; up_dn = 1'b1;
    repeat (3) @(negedge clk);
    check("first_step_pre", 32'(value_a), 32'h00);
    @(negedge clk);
    check("first_step", 32'(value_a), 32'h01);
    repeat (36) @(negedge clk);
    check("count40_bcd", 32'(value_a), 32'h10);
    check("count40_hex", 32'(value_c), 32'hA);

    load_val = 8'h99; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    check("load99", 32'(value_a), 32'h99);
    repeat (4) @(negedge clk);
    check("up_wrap_value", 32'(value_a), 32'h00);
    check("up_wrap_pulse", 32'(wrap_a), 32'h1);
    check("hex_no_wrap", 32'(wrap_c), 32'h0);
    @(negedge clk);
    check("wrap_one_cycle", 32'(wrap_a), 32'h0);
    up_dn = 1'b0;
    repeat (3) @(negedge clk);
    check("down_wrap_value", 32'(value_a), 32'h99);
    check("down_wrap_pulse", 32'(wrap_a), 32'h1);

    up_dn = 1'b1;
    repeat (3) @(negedge clk);
    clear = 1'b1; load = 1'b1; load_val = 8'h55;
    @(negedge clk);
    clear = 1'b0; load = 1'b0;
    check("clear_wins", 32'(value_a), 32'h00);
    check("clear_no_wrap", 32'(wrap_a), 32'h0);
    repeat (3) @(negedge clk);
    check("ps_restart_pre", 32'(value_a), 32'h00);
    @(negedge clk);
    check("ps_restart", 32'(value_a), 32'h01);

    en = 1'b0;
    repeat (20) @(negedge clk);
    check("hold_value", 32'(value_a), 32'h01);
    en = 1'b1;
    repeat (3) @(negedge clk);
    check("hold_ps_pre", 32'(value_a), 32'h01);
    @(negedge clk);
    check("hold_ps", 32'(value_a), 32'h02);

    en = 1'b0; load_val = 8'h07; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      if (dig_a == 2'b10) begin
        check("blank_d1", 32'(seg_b), 32'h00);
        check("noblank_d1", 32'(seg_a), 32'h3F);
      end else begin
        check("blank_d0", 32'(seg_b), 32'h07);
        check("noblank_d0", 32'(seg_a), 32'h07);
      end
      @(negedge clk);
    end

    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0; en = 1'b1; up_dn = 1'b1;
    repeat (64) @(negedge clk);
    check("hex_full_wrap", 32'(value_c), 32'h0);
    check("hex_wrap_pulse", 32'(wrap_c), 32'h1);
    check("bcd_16", 32'(value_a), 32'h16);

    for (int i = 0; i < 600; i++) begin
      n = int'($urandom_range(0, 99));
      en       = (n < 80);
      up_dn    = $urandom_range(0, 1) != 0;
      clear    = ($urandom_range(0, 99) < 3);
      load     = ($urandom_range(0, 99) < 5);
      load_val = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
      @(negedge clk);
    end
    clear = 1'b0; load = 1'b0; en = 1'b1; up_dn = 1'b1;
    load_val = 8'h42; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_value", 32'(value_a), 32'h0);
    check("async_seg", 32'(seg_a), 32'h0);
    check("async_dig", 32'(dig_a), 32'h0);
    check("async_wrap", 32'(wrap_a), 32'h0);
    check("async_value_c", 32'(value_c), 32'h0);
    check("async_seg_c", 32'(seg_c), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    n = total;
    check("scoreboard_activity", 32'(n > 3000), 32'h1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
